// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encoding, grant type, default widths.
// Optional round-robin arbitration is enabled with the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 48;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BUSY = 2'd1,
    WR_BUSY = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selector: picks which requester gets the memory port next.
// Writes win on an address hazard; otherwise the requester not granted last wins a tie.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic rd_req_i,
  input  logic wr_req_i,
  input  logic addr_eq_i,
  input  gnt_e last_grant_i,
  output gnt_e gnt_o,
  output logic gnt_vld_o
);

  always_comb begin
    gnt_vld_o = rd_req_i | wr_req_i;
    gnt_o     = GNT_WR;
    if (rd_req_i && !wr_req_i) begin
      gnt_o = GNT_RD;
    end else if (rd_req_i && wr_req_i && !addr_eq_i && (last_grant_i == GNT_WR)) begin
      gnt_o = GNT_RD;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between the MEM-stage reader and the WB-stage writer.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default build uses fixed write priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall_rd,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_done,
  output logic              stall_wr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;

  gnt_e gnt;
  gnt_e last_grant;
  logic gnt_vld;
  logic addr_eq;

  assign addr_eq = (rd_addr == wr_addr);

  mem_arb_sel u_sel (
    .rd_req_i     (rd_req),
    .wr_req_i     (wr_req),
    .addr_eq_i    (addr_eq),
    .last_grant_i (last_grant),
    .gnt_o        (gnt),
    .gnt_vld_o    (gnt_vld)
  );

`ifdef MEM_ARB_RR_EN
  gnt_e last_grant_q, last_grant_d;

  assign last_grant = last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && gnt_vld) begin
      last_grant_d = gnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_WR;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Pretending the read was granted last makes every tie resolve to the write.
  assign last_grant = GNT_RD;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          mem_req_d = 1'b1;
          if (gnt == GNT_WR) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            state_d     = WR_BUSY;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = rd_addr;
            state_d    = RD_BUSY;
          end
        end
      end
      RD_BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          rd_data_d = mem_rdata;
          rd_done_d = 1'b1;
          state_d   = DONE;
        end
      end
      WR_BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          wr_done_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Requests are ignored here so the requester can drop its req after the done pulse.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_done   = rd_done_q;
  assign wr_done   = wr_done_q;
  assign stall_rd  = rd_req & ~rd_done_q;
  assign stall_wr  = wr_req & ~wr_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then randomized traffic
// against a behavioural memory and grant-rule model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, wr_req, rd_done, wr_done, stall_rd, stall_wr;
  logic [AW-1:0] rd_addr, wr_addr, mem_addr;
  logic [DW-1:0] rd_data, wr_data, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_done   (rd_done),
    .rd_data   (rd_data),
    .stall_rd  (stall_rd),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_done   (wr_done),
    .stall_wr  (stall_wr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem_store [logic [AW-1:0]];
  logic [DW-1:0] ref_mem   [logic [AW-1:0]];

  int            ack_delay = 1;
  int            cnt = 0;
  bit            ack_sent = 0;
  bit            auto_ack = 1;
  bit            rand_delay = 0;
  bit            prev_mem_req = 0;
  bit            rd_pend = 0;
  bit            wr_pend = 0;
  bit            last_wr = 1;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wd = '0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a[15:0], ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: writes win ties and hazards; RR build alternates on non-hazard ties.
  function automatic bit model_gnt_wr();
    if (rd_req && wr_req) begin
      if (rd_addr == wr_addr) return 1'b1;
`ifdef MEM_ARB_RR_EN
      return !last_wr;
`else
      return 1'b1;
`endif
    end
    return wr_req;
  endfunction

  task automatic tick();
    logic [DW-1:0] exp_rd;
    @(posedge clk);
    #1;
    if (auto_ack) begin
      if (mem_ack) mem_ack = 1'b0;
      if (!mem_req) begin
        cnt = 0;
        ack_sent = 0;
        if (rand_delay) ack_delay = int'($urandom_range(0, 3));
      end else if (!ack_sent) begin
        cnt++;
        if (cnt == ack_delay + 1) begin
          mem_ack = 1'b1;
          ack_sent = 1;
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else if (mem_store.exists(mem_addr)) mem_rdata = mem_store[mem_addr];
          else mem_rdata = init_val(mem_addr);
        end
      end
    end
    if (mem_req && !prev_mem_req) begin
      exp_we   = model_gnt_wr();
      exp_addr = exp_we ? wr_addr : rd_addr;
      exp_wd   = wr_data;
      last_wr  = exp_we;
      chk("grant_we", mem_we, exp_we);
      chk("grant_addr", mem_addr, exp_addr);
      if (exp_we) chk("grant_wdata", mem_wdata, exp_wd);
    end else if (mem_req) begin
      chk("hold_we", mem_we, exp_we);
      chk("hold_addr", mem_addr, exp_addr);
    end
    prev_mem_req = mem_req;
    chk("stall_rd", stall_rd, rd_req && !rd_done);
    chk("stall_wr", stall_wr, wr_req && !wr_done);
    if (rd_done) begin
      chk("rd_done_expected", rd_pend, 1);
      if (ref_mem.exists(rd_addr)) exp_rd = ref_mem[rd_addr];
      else exp_rd = init_val(rd_addr);
      chk("rd_data", rd_data, exp_rd);
      rd_pend = 0;
    end
    if (wr_done) begin
      chk("wr_done_expected", wr_pend, 1);
      ref_mem[wr_addr] = wr_data;
      wr_pend = 0;
    end
  endtask

  // which: 0 = mem_req, 1 = rd_done, 2 = wr_done
  task automatic wait_for(input string tag, input int which, input int max, output int n);
    logic sig;
    n = 0;
    sig = 1'b0;
    while (!sig && n < max) begin
      tick();
      n++;
      case (which)
        0:       sig = mem_req;
        1:       sig = rd_done;
        default: sig = wr_done;
      endcase
    end
    chk(tag, sig, 1);
  endtask

  logic [AW-1:0] addrs [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
  logic [63:0]   r64;
  int            n;
  int            rd_wait = 0;
  int            wr_wait = 0;

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_stall_rd", stall_rd, 0);
    chk("rst_stall_wr", stall_wr, 0);

    // Lone read, memory acks two cycles after mem_req
    mem_store[32'h100] = 48'h00AA55AA55AA;
    ref_mem[32'h100]   = 48'h00AA55AA55AA;
    ack_delay = 2;
    rd_addr = 32'h100; rd_req = 1'b1; rd_pend = 1;
    #1;
    chk("lone_stall_rd_high", stall_rd, 1);
    wait_for("lone_rd_done_seen", 1, 20, n);
    chk("lone_latency", n, 4);
    chk("lone_rd_data", rd_data, 48'h00AA55AA55AA);
    chk("lone_stall_rd_low", stall_rd, 0);
    rd_req = 1'b0;
    tick();
    chk("lone_done_one_cycle", rd_done, 0);
    chk("lone_rd_data_held", rd_data, 48'h00AA55AA55AA);

    // Simultaneous requests, different addresses: write first
    ack_delay = 1;
    rd_addr = 32'h200; wr_addr = 32'h300; wr_data = 48'h1234;
    rd_req = 1'b1; wr_req = 1'b1; rd_pend = 1; wr_pend = 1;
    wait_for("simul_first_req", 0, 10, n);
    chk("simul_first_we", mem_we, 1);
    chk("simul_first_addr", mem_addr, 32'h300);
    wait_for("simul_wr_done", 2, 20, n);
    wr_req = 1'b0;
    wait_for("simul_second_req", 0, 10, n);
    chk("simul_second_we", mem_we, 0);
    chk("simul_second_addr", mem_addr, 32'h200);
    wait_for("simul_rd_done", 1, 20, n);
    rd_req = 1'b0;
    tick();

    // Address hazard after a read grant: write still goes first, read sees the new data
    rd_addr = 32'h400; wr_addr = 32'h400; wr_data = 48'hBEEF0000CAFE;
    rd_req = 1'b1; wr_req = 1'b1; rd_pend = 1; wr_pend = 1;
    wait_for("hazard_first_req", 0, 10, n);
    chk("hazard_we", mem_we, 1);
    chk("hazard_addr", mem_addr, 32'h400);
    wait_for("hazard_wr_done", 2, 20, n);
    wr_req = 1'b0;
    wait_for("hazard_rd_done", 1, 20, n);
    chk("hazard_raw_data", rd_data, 48'hBEEF0000CAFE);
    rd_req = 1'b0;
    tick();

    // Reset while a read is in flight
    ack_delay = 10;
    rd_addr = 32'h500; rd_req = 1'b1; rd_pend = 1;
    wait_for("rst_mid_req", 0, 10, n);
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", mem_req, 0);
    rd_req = 1'b0; rd_pend = 0; last_wr = 1;
    tick();
    chk("rst_no_rd_done_a", rd_done, 0);
    tick();
    chk("rst_no_rd_done_b", rd_done, 0);
    rst = 1'b0;
    tick();

    // Spurious ack in IDLE with no requests
    auto_ack = 0;
    mem_ack = 1'b1; mem_rdata = 48'hFFFFFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    chk("spur_mem_req", mem_req, 0);
    chk("spur_mem_we", mem_we, 0);
    chk("spur_mem_addr", mem_addr, 0);
    chk("spur_mem_wdata", mem_wdata, 0);
    chk("spur_rd_data", rd_data, 0);
    chk("spur_rd_done", rd_done, 0);
    chk("spur_wr_done", wr_done, 0);
    auto_ack = 1; cnt = 0; ack_sent = 0;

    // A fresh read after reset shows the FSM restarted from IDLE
    ack_delay = 2;
    rd_addr = 32'h100; rd_req = 1'b1; rd_pend = 1;
    wait_for("post_rst_rd_done", 1, 20, n);
    chk("post_rst_latency", n, 4);
    rd_req = 1'b0;
    tick();

    // Randomized traffic with hazards and variable memory latency
    rand_delay = 1;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (rd_req && !rd_pend) begin
        rd_req = 1'b0;
      end else if (!rd_req && $urandom_range(0, 2) == 0) begin
        rd_addr = addrs[$urandom_range(0, 3)];
        rd_req = 1'b1; rd_pend = 1; rd_wait = 0;
      end
      if (wr_req && !wr_pend) begin
        wr_req = 1'b0;
      end else if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_addr = addrs[$urandom_range(0, 3)];
        r64 = {$urandom(), $urandom()};
        wr_data = r64[DW-1:0];
        wr_req = 1'b1; wr_pend = 1; wr_wait = 0;
      end
      if (rd_pend && ++rd_wait > 40) begin
        chk("rd_timeout", rd_done, 1);
        rd_pend = 0; rd_req = 1'b0;
      end
      if (wr_pend && ++wr_wait > 40) begin
        chk("wr_timeout", wr_done, 1);
        wr_pend = 0; wr_req = 1'b0;
      end
    end
    for (int c = 0; c < 100 && (rd_pend || wr_pend); c++) begin
      tick();
      if (rd_req && !rd_pend) rd_req = 1'b0;
      if (wr_req && !wr_pend) wr_req = 1'b0;
    end
    chk("drain_complete", {rd_pend, wr_pend}, 0);
    rd_req = 1'b0; wr_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
